iic_slave_byte_engine: RTL

//  Second-generation IIC slave byte engine. It replaces the externally sequenced SDA driver with
//  its own bit counter, state machine, address pointer and shift registers.

---
 rtl/iic_slave_byte_engine.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/iic_slave_byte_engine.sv
// IIC slave byte engine: device select, word address, page-wrapped writes
// and sequential reads with master ACK/NACK, driven by SCL/SDA strobes.
module iic_slave_byte_engine #(
   parameter int         ADDR_BYTES = 2,
   parameter int         PAGE_BYTES = 32,
   parameter logic [3:0] DEV_ID     = 4'b1010
) (
   input  logic                      iic_clk_c,
   input  logic                      iic_frm_rst_n,
   input  logic                      iic_start,
   input  logic                      iic_stop,
   input  logic                      iic_scl_rise,
   input  logic                      iic_scl_fall,
   input  logic                      iic_sda_in,
   input  logic [2:0]                iic_dev_sel,
   input  logic                      iic_hwp_val,
   input  logic [7:0]                iic_usr_dout,
   output logic                      iic_sda_out,
   output logic [8*ADDR_BYTES-1:0]   iic_addr,
   output logic                      iic_wr_vld,
   output logic [7:0]                iic_wr_data,
   output logic                      iic_rd_stb,
   output logic                      iic_busy
);

   localparam int ADDR_W = 8 * ADDR_BYTES;
   localparam int PG_W   = $clog2(PAGE_BYTES);
   localparam int IDX_W  = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
   localparam logic [ADDR_W-1:0] PG_MASK = ADDR_W'((64'd1 << PG_W) - 64'd1);

   typedef enum logic [2:0] {
      IDLE,
      DEV,
      ADDR,
      WR,
      RD,
      WAIT
   } state_t;

   state_t            state;
   logic [3:0]        bcnt;
   logic [7:0]        rx;
   logic [6:0]        tx;
   logic [IDX_W-1:0]  idx;
   logic              wrote;
   logic              mack;
   logic              active;
   logic              dev_hit;
   logic [ADDR_W-1:0] addr_inc;
   logic [ADDR_W-1:0] addr_pg;

   assign active   = (state == DEV) || (state == ADDR) ||
                     (state == WR)  || (state == RD);
   assign dev_hit  = (rx[7:1] == {DEV_ID, iic_dev_sel});
   assign addr_inc = iic_addr + ADDR_W'(1);
   // Page writes only advance the in-page offset bits.
   assign addr_pg  = (iic_addr & ~PG_MASK) | (addr_inc & PG_MASK);
   assign iic_busy = (state != IDLE);

   always_ff @(posedge iic_clk_c) begin
      if (!iic_frm_rst_n) begin
         state       <= IDLE;
         bcnt        <= '0;
         rx          <= '0;
         tx          <= '0;
         idx         <= '0;
         wrote       <= 1'b0;
         mack        <= 1'b1;
         iic_sda_out <= 1'b1;
         iic_addr    <= '0;
         iic_wr_vld  <= 1'b0;
         iic_wr_data <= '0;
         iic_rd_stb  <= 1'b0;
      end else begin
         iic_wr_vld <= 1'b0;
         iic_rd_stb <= 1'b0;
         if (iic_start) begin
            state       <= DEV;
            bcnt        <= '0;
            idx         <= '0;
            wrote       <= 1'b0;
            iic_sda_out <= 1'b1;
         end else if (iic_stop) begin
            state       <= IDLE;
            bcnt        <= '0;
            wrote       <= 1'b0;
            iic_sda_out <= 1'b1;
         end else if (active) begin
            if (iic_scl_rise) begin
               if (bcnt < 4'd8) begin
                  rx <= {rx[6:0], iic_sda_in};
               end else if (state == RD) begin
                  mack <= iic_sda_in;
                  if (!iic_sda_in)
                     iic_addr <= addr_inc;
               end
            end
            if (iic_scl_fall) begin
               if (bcnt == 4'd8) begin
                  bcnt        <= '0;
                  iic_sda_out <= 1'b1;
                  unique case (state)
                     DEV: begin
                        if (!dev_hit) begin
                           state <= WAIT;
                        end else if (rx[0]) begin
                           state       <= RD;
                           tx          <= iic_usr_dout[6:0];
                           iic_rd_stb  <= 1'b1;
                           iic_sda_out <= iic_usr_dout[7];
                        end else begin
                           state <= ADDR;
                           idx   <= '0;
                        end
                     end
                     ADDR: begin
                        for (int i = 0; i < ADDR_BYTES; i++)
                           if (idx == IDX_W'(ADDR_BYTES - 1 - i))
                              iic_addr[8*i +: 8] <= rx;
                        if (idx == IDX_W'(ADDR_BYTES - 1))
                           state <= WR;
                        else
                           idx <= idx + 1'b1;
                     end
                     WR: begin
                        if (wrote) begin
                           iic_addr <= addr_pg;
                           wrote    <= 1'b0;
                        end
                     end
                     RD: begin
                        if (mack) begin
                           state <= WAIT;
                        end else begin
                           tx          <= iic_usr_dout[6:0];
                           iic_rd_stb  <= 1'b1;
                           iic_sda_out <= iic_usr_dout[7];
                        end
                     end
                     default: begin
                     end
                  endcase
               end else begin
                  bcnt <= bcnt + 4'd1;
                  if (bcnt == 4'd7) begin
                     unique case (state)
                        DEV:  iic_sda_out <= !dev_hit;
                        ADDR: iic_sda_out <= 1'b0;
                        WR: begin
                           if (iic_hwp_val) begin
                              iic_sda_out <= 1'b1;
                           end else begin
                              iic_sda_out <= 1'b0;
                              iic_wr_vld  <= 1'b1;
                              iic_wr_data <= rx;
                              wrote       <= 1'b1;
                           end
                        end
                        RD:   iic_sda_out <= 1'b1;
                        default: begin
                        end
                     endcase
                  end else if (state == RD) begin
                     iic_sda_out <= tx[6];
                     tx          <= {tx[5:0], 1'b0};
                  end
               end
            end
         end
      end
   end

endmodule
